// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages and the pipeline controller.
// The stages act as master (raise requests); the controller is the slave (returns controls).
interface pipe_ctrl_if #(
    parameter int unsigned NSTAGE = 5
);
    logic [NSTAGE-1:0]        stall_req;
    logic [NSTAGE*NSTAGE-1:0] flush_req;
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic [NSTAGE-1:0]        stall;
    logic [NSTAGE-1:0]        flush;
    logic                     pc_w_enable;
    logic [31:0]              new_pc;

    modport master (
        output stall_req, flush_req, redirect_valid, redirect_pc,
        input  stall, flush, pc_w_enable, new_pc
    );

    modport slave (
        input  stall_req, flush_req, redirect_valid, redirect_pc,
        output stall, flush, pc_w_enable, new_pc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall/flush requests, defers redirects that hit
// frozen stages until the stall clears, and tracks stall statistics plus a watchdog.
module pipe_ctrl #(
    parameter int unsigned NSTAGE        = 5,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_if.slave       ctrl,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);
    localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {StInit, StRun, StHold, StPend} state_e;

    state_e            state_q, state_d;
    logic [NSTAGE-1:0] pend_mask_q, pend_mask_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic              pend_redir_q, pend_redir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              to_q, to_d;

    logic [NSTAGE-1:0] stall_mask, bubble, f_merge;
    logic              any_req, conflict, any_stall, acc;

    // Stall covers every stage at or below the highest requester; bubble goes just behind it.
    always_comb begin
        stall_mask = '0;
        bubble     = '0;
        f_merge    = '0;
        acc        = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc           = acc | ctrl.stall_req[i];
            stall_mask[i] = acc;
        end
        for (int i = 0; i < NSTAGE - 1; i++) begin
            bubble[i+1] = ctrl.stall_req[i] & ~stall_mask[i+1];
        end
        for (int k = 0; k < NSTAGE; k++) begin
            f_merge = f_merge | ctrl.flush_req[k*NSTAGE +: NSTAGE];
        end
    end

    assign any_req   = |ctrl.stall_req;
    assign conflict  = |(f_merge & stall_mask);
    assign any_stall = (state_q != StInit) && any_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            pend_mask_q  <= '0;
            pend_pc_q    <= '0;
            pend_redir_q <= 1'b0;
            cnt_q        <= '0;
            run_q        <= '0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_mask_q  <= pend_mask_d;
            pend_pc_q    <= pend_pc_d;
            pend_redir_q <= pend_redir_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            to_q         <= to_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_mask_d  = pend_mask_q;
        pend_pc_d    = pend_pc_q;
        pend_redir_d = pend_redir_q;
        unique case (state_q)
            StInit: begin
                state_d      = StRun;
                pend_mask_d  = '0;
                pend_redir_d = 1'b0;
            end
            StRun, StHold: begin
                if (!any_req) begin
                    state_d = StRun;
                end else if (conflict) begin
                    state_d      = StPend;
                    pend_mask_d  = f_merge;
                    pend_pc_d    = ctrl.redirect_pc;
                    pend_redir_d = ctrl.redirect_valid;
                end else begin
                    state_d = StHold;
                end
            end
            StPend: begin
                if (!any_req) begin
                    state_d      = StRun;
                    pend_mask_d  = '0;
                    pend_redir_d = 1'b0;
                end else begin
                    // Everything arriving while pending is folded in so order is preserved.
                    pend_mask_d = pend_mask_q | f_merge;
                    if (ctrl.redirect_valid) begin
                        pend_pc_d    = ctrl.redirect_pc;
                        pend_redir_d = 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        ctrl.stall       = '0;
        ctrl.flush       = '0;
        ctrl.pc_w_enable = 1'b0;
        ctrl.new_pc      = '0;
        unique case (state_q)
            StInit: ctrl.flush = '1;
            StRun, StHold: begin
                ctrl.stall  = stall_mask;
                ctrl.new_pc = ctrl.redirect_pc;
                if (any_req && conflict) begin
                    ctrl.flush = bubble;
                end else begin
                    ctrl.flush       = bubble | f_merge;
                    ctrl.pc_w_enable = ctrl.redirect_valid;
                end
            end
            StPend: begin
                ctrl.stall  = stall_mask;
                ctrl.new_pc = ctrl.redirect_valid ? ctrl.redirect_pc : pend_pc_q;
                if (any_req) begin
                    ctrl.flush = bubble;
                end else begin
                    ctrl.flush       = pend_mask_q | f_merge;
                    ctrl.pc_w_enable = pend_redir_q | ctrl.redirect_valid;
                end
            end
            default: ctrl.flush = '1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        run_d = '0;
        to_d  = to_q;
        if (any_stall) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            run_d = (run_q == RUN_W'(STALL_TIMEOUT)) ? run_q : run_q + 1'b1;
            if ((32'(run_q) + 32'd1) >= STALL_TIMEOUT) begin
                to_d = 1'b1;
            end
        end
    end

    assign stall_cycles  = cnt_q;
    assign stall_timeout = to_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model queues expected controls,
// and a monitor compares them against the DUT each cycle.
module tb_pipe_ctrl;
    localparam int unsigned NS = 5;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] stall_cycles;
    logic          stall_timeout;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.NSTAGE(NS)) bus ();

    pipe_ctrl #(
        .NSTAGE       (NS),
        .STALL_TIMEOUT(TO),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl         (bus),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );

    typedef struct {
        logic [NS-1:0] stall;
        logic [NS-1:0] flush;
        logic          pcw;
        logic          chk_pc;
        logic [31:0]   npc;
        logic [CW-1:0] sc;
        logic          to;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference state: described in terms of "a redirect is outstanding", not FSM states.
    bit            m_init = 1'b1;
    bit            m_pend = 1'b0;
    logic [NS-1:0] m_pmask = '0;
    logic [31:0]   m_ppc = '0;
    bit            m_predir = 1'b0;
    int            m_sc = 0;
    int            m_run = 0;
    bit            m_to = 1'b0;

    function automatic void model_step(input logic r, input logic [NS-1:0] sr,
                                       input logic [NS*NS-1:0] fr, input logic rv,
                                       input logic [31:0] pc);
        exp_t          e;
        int            k;
        logic [NS-1:0] stl, bub, f;
        e.stall = '0; e.flush = '1; e.pcw = 1'b0; e.chk_pc = 1'b1; e.npc = '0;
        if (!r) begin
            m_init = 1'b1; m_pend = 1'b0; m_predir = 1'b0; m_pmask = '0;
            m_sc = 0; m_run = 0; m_to = 1'b0;
            e.sc = '0; e.to = 1'b0;
            sbq.push_back(e);
            return;
        end
        e.sc = CW'(m_sc);
        e.to = m_to;
        if (m_init) begin
            m_init = 1'b0;
            m_run  = 0;
            sbq.push_back(e);
            return;
        end
        k = -1;
        for (int i = 0; i < NS; i++) if (sr[i]) k = i;
        stl = '0;
        for (int i = 0; i < NS; i++) if (i <= k) stl[i] = 1'b1;
        bub = (k >= 0 && k < NS - 1) ? (NS'(1) << (k + 1)) : '0;
        f = '0;
        for (int s = 0; s < NS; s++) f = f | fr[s*NS +: NS];
        e.stall = stl;
        e.chk_pc = 1'b0;
        if (k < 0) begin
            if (m_pend) begin
                e.flush = m_pmask | f;
                e.pcw   = m_predir | rv;
                e.npc   = rv ? pc : m_ppc;
                m_pend  = 1'b0;
            end else begin
                e.flush = f;
                e.pcw   = rv;
                e.npc   = pc;
            end
            e.chk_pc = e.pcw;
        end else if (m_pend) begin
            e.flush = bub;
            e.pcw   = 1'b0;
            m_pmask = m_pmask | f;
            if (rv) begin m_ppc = pc; m_predir = 1'b1; end
        end else if ((f & stl) != '0) begin
            e.flush = bub;
            e.pcw   = 1'b0;
            m_pend = 1'b1; m_pmask = f; m_ppc = pc; m_predir = rv;
        end else begin
            e.flush  = bub | f;
            e.pcw    = rv;
            e.npc    = pc;
            e.chk_pc = rv;
        end
        if (k >= 0) begin
            if (m_sc < (2 ** CW) - 1) m_sc++;
            m_run++;
            if (m_run >= TO) m_to = 1'b1;
        end else begin
            m_run = 0;
        end
        sbq.push_back(e);
    endfunction

    task automatic drive(input logic r, input logic [NS-1:0] sr, input logic [NS*NS-1:0] fr,
                         input logic rv, input logic [31:0] pc);
        @(negedge clk);
        rst_n              = r;
        bus.stall_req      = sr;
        bus.flush_req      = fr;
        bus.redirect_valid = rv;
        bus.redirect_pc    = pc;
        model_step(r, sr, fr, rv, pc);
    endtask

    function automatic logic [NS*NS-1:0] slice(input int s, input logic [NS-1:0] m);
        logic [NS*NS-1:0] v;
        v = '0;
        v[s*NS +: NS] = m;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        #2;
        cyc++;
        if (sbq.size() > 0) begin
            e  = sbq.pop_front();
            ok = (bus.stall == e.stall) && (bus.flush == e.flush) &&
                 (bus.pc_w_enable == e.pcw) && (!e.chk_pc || bus.new_pc == e.npc) &&
                 (stall_cycles == e.sc) && (stall_timeout == e.to);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL cycle%0d: got stall=%b flush=%b pcw=%b pc=%h sc=%0d to=%b; want stall=%b flush=%b pcw=%b pc=%h(chk=%b) sc=%0d to=%b",
                         cyc, bus.stall, bus.flush, bus.pc_w_enable, bus.new_pc, stall_cycles,
                         stall_timeout, e.stall, e.flush, e.pcw, e.npc, e.chk_pc, e.sc, e.to);
            end
        end
    end

    initial begin
        logic [NS-1:0]    sr_hold;
        int               hold;
        logic [NS*NS-1:0] fr;
        bus.stall_req = '0; bus.flush_req = '0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        // Reset release, INIT cycle, then quiet RUN.
        drive(0, '0, '0, 0, 0); drive(0, '0, '0, 0, 0);
        drive(1, '0, '0, 0, 0); drive(1, '0, '0, 0, 0);
        // Stall at EX for three cycles.
        repeat (3) drive(1, 5'b00100, '0, 0, 0);
        drive(1, '0, '0, 0, 0);
        // Immediate redirect.
        drive(1, '0, slice(2, 5'b00110), 1, 32'h80);
        // Redirect deferred behind a MEM stall.
        drive(1, 5'b01000, slice(2, 5'b00110), 1, 32'h40);
        drive(1, 5'b01000, '0, 0, 0);
        drive(1, '0, '0, 0, 0);
        // Pending redirect superseded by a live one at stall drop.
        drive(1, 5'b01000, slice(2, 5'b00110), 1, 32'h40);
        drive(1, 5'b01000, '0, 0, 0);
        drive(1, '0, slice(2, 5'b00011), 1, 32'h100);
        // Reset while pending discards the redirect.
        drive(1, 5'b01000, slice(2, 5'b00110), 1, 32'h40);
        drive(0, 5'b01000, '0, 0, 0);
        drive(1, '0, '0, 0, 0);
        repeat (3) drive(1, '0, '0, 0, 0);
        // Watchdog.
        drive(0, '0, '0, 0, 0); drive(1, '0, '0, 0, 0);
        repeat (8) drive(1, 5'b00001, '0, 0, 0);
        repeat (3) drive(1, '0, '0, 0, 0);
        drive(0, '0, '0, 0, 0); drive(1, '0, '0, 0, 0);
        // WB stall freezes all with no bubble.
        drive(1, 5'b10000, '0, 0, 0);
        drive(1, '0, '0, 0, 0);
        // Randomized traffic.
        hold = 0;
        sr_hold = '0;
        for (int n = 0; n < 1500; n++) begin
            if (hold == 0) begin
                sr_hold = ($urandom_range(0, 9) < 4) ? '0 : NS'($urandom_range(1, 31));
                hold    = $urandom_range(1, 6);
            end
            hold--;
            fr = ($urandom_range(0, 3) == 0) ?
                 slice($urandom_range(0, NS - 1), NS'($urandom_range(0, 31))) : '0;
            drive(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, sr_hold, fr,
                  ($urandom_range(0, 3) == 0), $urandom);
        end
        drive(1, '0, '0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left, want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core (IF=0, ID=1, EX=2, MEM=3, WB=4).
- Merges per-stage stall and flush requests into per-stage stall/flush controls and sequences the PC redirect to fetch.
- When a redirect arrives while the target stages are frozen, it defers the flush and redirect and replays them once the stall clears.
- Maintains a stall performance counter and a stall watchdog.

Parameters:
NSTAGE, 5, number of pipeline stages (index 0 = IF).
STALL_TIMEOUT, 1024, consecutive stall cycles before stall_timeout is raised.
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
stall_req  in  NSTAGE  bit k = stage k requests a stall this cycle
flush_req  in  NSTAGE*NSTAGE  slice [k*NSTAGE +: NSTAGE] = flush mask requested by stage k
redirect_valid  in  1  branch/jump taken (from EX), same cycle as its flush request
redirect_pc  in  32  target PC for redirect_valid
stall  out  NSTAGE  per-stage hold
flush  out  NSTAGE  per-stage bubble/clear
pc_w_enable  out  1  fetch loads new_pc this cycle
new_pc  out  32  redirect target presented to fetch
stall_cycles  out  CNT_W  saturating count of cycles with any stall
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Stall merge (combinational):
  - k = highest index with stall_req[k]=1.
  - stall[i]=1 for all i<=k.
  - If k<NSTAGE-1, flush[k+1]=1 (bubble behind the frozen stage).
  - No stall_req bits set → stall=0.
- Flush merge: F = OR of all flush_req slices.
- Flush vs stall:
  - Flush bits landing on unstalled stages apply immediately.
  - If any bit of F lands on a stalled stage, the whole F, plus redirect_pc if redirect_valid, is latched as pending. Nothing from that F or the redirect is applied this cycle.
- FSM states: INIT, RUN, HOLD, PEND.
  - INIT: entered on reset. Drives flush=all-ones, stall=0, pc_w_enable=0 for exactly one cycle after rst_n deasserts, then → RUN.
  - RUN:
    - No stall: apply F; pc_w_enable=redirect_valid; new_pc=redirect_pc (combinational, same cycle).
    - Stall with no conflict → HOLD.
    - Stall with conflict → PEND (latch pend_mask=F, pend_pc, pend_redir).
  - HOLD:
    - Stall merge as above.
    - Stall drops → RUN.
    - Conflicting flush/redirect arrives → PEND.
  - PEND:
    - Stall merge active; pending request retained.
    - A new redirect overwrites pend_pc and ORs its mask into pend_mask (latest target wins).
    - First cycle with stall_req=0: flush = pend_mask | F, pc_w_enable = pend_redir | redirect_valid, new_pc = live redirect_pc if redirect_valid else pend_pc. Clear pending, → RUN.
- Simultaneous stall drop and new redirect in PEND: live request wins the PC, masks are merged.
- stall_req[NSTAGE-1] (WB): freezes the whole pipe; no bubble is generated.
- Counters:
  - stall_cycles increments on every cycle with |stall, saturating at all-ones.
  - A run counter counts consecutive stall cycles and clears on any non-stall cycle. When it reaches STALL_TIMEOUT, stall_timeout sets and stays set until reset.
- Reset: asynchronous on rst_n low. All registers clear and the FSM goes to INIT. Outputs during reset: flush=all-ones, stall=0, pc_w_enable=0, new_pc=0, stall_cycles=0, stall_timeout=0. Reset mid-PEND discards the pending redirect.
- Latency:
  - Stall/flush/redirect with no conflict: 0 cycles (combinational).
  - Deferred redirect: applied in the first cycle the stall is gone.

Test Plan:
- Reset release → exactly one cycle flush=5'b11111, stall=0, then flush=0 in RUN with no requests.
- stall_req=5'b00100 for 3 cycles → stall=5'b00111, flush=5'b01000 each cycle; stall_cycles=3; back to RUN on release.
- RUN, flush_req slice2=5'b00110, redirect_valid=1, redirect_pc=32'h80 → same cycle flush=5'b00110, pc_w_enable=1, new_pc=32'h80.
- stall_req=5'b01000 held 2 cycles, EX flush 5'b00110 + redirect 32'h40 in first cycle only:
  - stall cycles: flush=5'b10000, pc_w_enable=0.
  - cycle after stall drop: flush=5'b00110, pc_w_enable=1, new_pc=32'h40.
- PEND with pend_pc=32'h40, stall drops while redirect_pc=32'h100 valid → new_pc=32'h100, flush=merged mask; rst_n pulsed low in PEND instead → no redirect ever issued.
- STALL_TIMEOUT=8, stall_req=5'b00001 held 8 cycles → stall_timeout=1 and stays 1 after release; cleared only by rst_n.
